// File: rtl/matrix_mult_pkg.sv
// Shared types, default geometry and width helpers for the systolic
// matrix-multiply sequencer.
package matrix_mult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_MUL   = 3'd3,
        ST_ADD   = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } mm_state_t;

    localparam int MM_N       = 4;
    localparam int MM_MUL_CYC = 6;
    localparam int MM_ADD_CYC = 8;

    // Counter/index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_mult_lane_window.sv
// Decodes the wavefront step into the skewed per-lane operand read mask:
// lane i reads during steps i .. i+N.
module matrix_mult_lane_window
    import matrix_mult_pkg::*;
#(
    parameter int N  = MM_N,
    parameter int SW = idx_w(3 * N)
) (
    input  logic          en,
    input  logic [SW-1:0] step,
    output logic [N-1:0]  mask
);

    localparam logic [SW-1:0] SPAN = SW'(N + 1);

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam logic [SW-1:0] LO = SW'(i);
        logic [SW-1:0] rel;

        // step < i wraps to a value far above SPAN, so one compare covers both bounds.
        assign rel     = step - LO;
        assign mask[i] = en && (rel < SPAN);
    end

endmodule

// File: rtl/matrix_mult_seq_ctrl.sv
// Sequencer for the NxN systolic multiplier: skewed operand loads, paced
// multiply/add phases, optional accumulator clear and a back-pressured drain.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// CLR      | one cycle, clears PE accumulators unless accumulating
// LOAD     | one cycle, shifts the array and strobes the skewed lanes
// MUL      | multiplier enabled for MUL_CYC cycles
// ADD      | adder enabled for ADD_CYC cycles
// DRAIN    | presents results row-major on the valid/ready port
// DONE     | one-cycle completion pulse
module matrix_mult_seq_ctrl
    import matrix_mult_pkg::*;
#(
    parameter int N       = MM_N,
    parameter int MUL_CYC = MM_MUL_CYC,
    parameter int ADD_CYC = MM_ADD_CYC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  accumulate,
    input  logic                  abort,
    output logic [N-1:0]          rd_a,
    output logic [N-1:0]          rd_b,
    output logic                  shift_en,
    output logic                  mult_en,
    output logic                  add_en,
    output logic                  acc_clr,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [idx_w(N)-1:0]   out_row,
    output logic [idx_w(N)-1:0]   out_col,
    output logic                  done
);

    localparam int SW = idx_w(3 * N);
    localparam int PW = idx_w((MUL_CYC > ADD_CYC) ? MUL_CYC : ADD_CYC);
    localparam int IW = idx_w(N);

    localparam logic [SW-1:0] STEP_LAST = SW'(3 * N - 1);
    localparam logic [PW-1:0] MUL_LAST  = PW'(MUL_CYC - 1);
    localparam logic [PW-1:0] ADD_LAST  = PW'(ADD_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

    mm_state_t     state, state_nxt;
    logic [SW-1:0] step;
    logic [PW-1:0] phase;
    logic [IW-1:0] row, col;
    logic          acc_keep;
    logic          load_go;
    logic [N-1:0]  lane_mask;

    assign load_go = (state == ST_LOAD) && (step < STEP_LAST);

    matrix_mult_lane_window #(
        .N  (N),
        .SW (SW)
    ) u_lane_window (
        .en   (load_go),
        .step (step),
        .mask (lane_mask)
    );

    // The final ADD goes straight to DRAIN: the step after the last wavefront
    // carries no strobes, so an extra empty LOAD would only add latency.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_CLR;
            ST_CLR:   state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = load_go ? ST_MUL : ST_DRAIN;
            ST_MUL:   if (phase == MUL_LAST) state_nxt = ST_ADD;
            ST_ADD: begin
                if (phase == ADD_LAST)
                    state_nxt = (step == STEP_LAST) ? ST_DRAIN : ST_LOAD;
            end
            ST_DRAIN: begin
                if (out_ready && (row == IDX_LAST) && (col == IDX_LAST))
                    state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (abort)
            state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            step     <= '0;
            phase    <= '0;
            row      <= '0;
            col      <= '0;
            acc_keep <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state)
                phase <= '0;
            else if ((state == ST_MUL) || (state == ST_ADD))
                phase <= phase + 1'b1;

            if (abort) begin
                step <= '0;
                row  <= '0;
                col  <= '0;
            end else begin
                case (state)
                    ST_IDLE:  if (start) acc_keep <= accumulate;
                    ST_CLR:   step <= '0;
                    ST_LOAD:  if (load_go) step <= step + 1'b1;
                    ST_DRAIN: begin
                        if (out_ready) begin
                            if (col == IDX_LAST) begin
                                col <= '0;
                                row <= (row == IDX_LAST) ? '0 : row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_a      = lane_mask;
    assign rd_b      = lane_mask;
    assign shift_en  = load_go;
    assign mult_en   = (state == ST_MUL);
    assign add_en    = (state == ST_ADD);
    assign acc_clr   = (state == ST_CLR) && !acc_keep;
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DRAIN);
    assign out_row   = row;
    assign out_col   = col;
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_matrix_mult_seq_ctrl.sv
// Directed bench for matrix_mult_seq_ctrl: default 4x4 build plus a 2x2,
// 1/1-cycle build sharing the clock and reset.
module tb_matrix_mult_seq_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start, accumulate, abort, out_ready;
    logic [3:0] rd_a, rd_b;
    logic       shift_en, mult_en, add_en, acc_clr, busy, out_valid, done;
    logic [1:0] out_row, out_col;

    logic       start2, out_ready2;
    logic [1:0] rd_a2, rd_b2;
    logic       shift_en2, mult_en2, add_en2, acc_clr2, busy2, out_valid2, done2;
    logic [0:0] out_row2, out_col2;

    int nvec = 0;
    int nmis = 0;

    matrix_mult_seq_ctrl u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .accumulate(accumulate),
        .abort(abort), .rd_a(rd_a), .rd_b(rd_b), .shift_en(shift_en),
        .mult_en(mult_en), .add_en(add_en), .acc_clr(acc_clr), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_col(out_col), .done(done)
    );

    matrix_mult_seq_ctrl #(.N(2), .MUL_CYC(1), .ADD_CYC(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .accumulate(1'b0),
        .abort(1'b0), .rd_a(rd_a2), .rd_b(rd_b2), .shift_en(shift_en2),
        .mult_en(mult_en2), .add_en(add_en2), .acc_clr(acc_clr2), .busy(busy2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_row(out_row2),
        .out_col(out_col2), .done(done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs_main();
        return int'({rd_a, rd_b, shift_en, mult_en, add_en, acc_clr, busy,
                     out_valid, out_row, out_col, done});
    endfunction

    // One full multiply on the 4x4 instance; bp stalls the consumer for
    // three cycles when (1,2) is first presented.
    task automatic run_mm(input bit accum, input bit bp, input string tag);
        int clr_n = 0, clr_c = -1, fv = -1, nacc = 0, idx_err = 0, hold_err = 0;
        int done_n = 0, done_c = -1, loads = 0, first_load = -1;
        int rd0m = 0, rd3m = 0, rd3n = 0, stray = 0, ab_diff = 0;
        int mul_n = 0, add_n = 0, valid_n = 0, bp_left;
        int idx;
        bp_left    = bp ? 3 : 0;
        accumulate = accum;
        out_ready  = 1'b1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        accumulate = 1'b0;
        for (int c = 1; c < 400 && done_n == 0; c++) begin
            if (out_valid && bp_left > 0 && out_row == 2'd1 && out_col == 2'd2) begin
                out_ready = 1'b0;
                bp_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (acc_clr) begin clr_n++; clr_c = c; end
            if (rd_a != rd_b) ab_diff++;
            if (rd_a[3]) rd3n++;
            if (shift_en) begin
                if (first_load < 0) first_load = c;
                if (rd_a[0]) rd0m |= (1 << loads);
                if (rd_a[3]) rd3m |= (1 << loads);
                loads++;
            end else if (rd_a != 4'd0 || rd_b != 4'd0) begin
                stray++;
            end
            if (mult_en) mul_n++;
            if (add_en) add_n++;
            if (out_valid) begin
                valid_n++;
                if (fv < 0) fv = c;
                idx = int'(out_row) * 4 + int'(out_col);
                if (idx != nacc) begin
                    if (out_ready) idx_err++;
                    else hold_err++;
                end
                if (out_ready) nacc++;
            end
            if (done) begin done_n++; done_c = c; end
            tick();
        end
        out_ready = 1'b1;
        chk({tag, ".clr_n"}, clr_n, accum ? 0 : 1);
        chk({tag, ".clr_cyc"}, clr_c, accum ? -1 : 1);
        chk({tag, ".first_load"}, first_load, 2);
        chk({tag, ".loads"}, loads, 11);
        chk({tag, ".rd0_steps"}, rd0m, 'h1F);
        chk({tag, ".rd3_steps"}, rd3m, 'hF8);
        chk({tag, ".rd3_count"}, rd3n, 5);
        chk({tag, ".stray_strobe"}, stray, 0);
        chk({tag, ".rd_ab_diff"}, ab_diff, 0);
        chk({tag, ".mul_cycles"}, mul_n, 66);
        chk({tag, ".add_cycles"}, add_n, 88);
        chk({tag, ".first_valid"}, fv, 167);
        chk({tag, ".n_results"}, nacc, 16);
        chk({tag, ".idx_seq_err"}, idx_err, 0);
        chk({tag, ".idx_hold_err"}, hold_err, 0);
        chk({tag, ".valid_cycles"}, valid_n, bp ? 19 : 16);
        chk({tag, ".done_cyc"}, done_c, bp ? 186 : 183);
        chk({tag, ".done_n"}, done_n, 1);
        chk({tag, ".busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int loads, adds, ab_c, dn, bz, fv2, nacc2, idx_err2, done_c2, done_n2, idx2;

        reset_n    = 1'b0;
        start      = 1'b0;
        accumulate = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b1;
        start2     = 1'b0;
        out_ready2 = 1'b1;
        repeat (3) tick();
        chk("reset.outs", outs_main(), 0);
        chk("reset.outs2", int'({rd_a2, busy2, out_valid2, out_row2, out_col2, done2, acc_clr2}), 0);
        reset_n = 1'b1;
        tick();

        run_mm(1'b0, 1'b0, "clear");
        tick();
        run_mm(1'b0, 1'b1, "backpressure");
        tick();

        // Reset in the middle of a run must discard progress.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        chk("midrst.busy_before", int'(busy), 1);
        reset_n = 1'b0;
        tick();
        chk("midrst.outs", outs_main(), 0);
        reset_n = 1'b1;
        tick();
        run_mm(1'b1, 1'b0, "accum");
        tick();

        // Abort in the 4th ADD cycle of step 5.
        start = 1'b1;
        tick();
        start = 1'b0;
        loads = 0;
        adds  = 0;
        ab_c  = -1;
        for (int c = 1; c < 200 && ab_c < 0; c++) begin
            if (shift_en) begin loads++; adds = 0; end
            if (add_en) begin
                adds++;
                if (loads == 6 && adds == 4) begin abort = 1'b1; ab_c = c; end
            end
            tick();
        end
        abort = 1'b0;
        chk("abort.cycle", ab_c, 87);
        chk("abort.outs_next", outs_main(), 0);
        dn = 0;
        bz = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) dn++;
            if (busy) bz++;
            tick();
        end
        chk("abort.no_done", dn, 0);
        chk("abort.stays_idle", bz, 0);
        run_mm(1'b0, 1'b0, "after_abort");
        tick();

        // 2x2 build with a start attempt while busy.
        fv2 = -1; nacc2 = 0; idx_err2 = 0; done_c2 = -1; done_n2 = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 1; c < 60; c++) begin
            start2 = (c == 5) ? 1'b1 : 1'b0;
            if (c == 5) chk("n2.busy_at_restart", int'(busy2), 1);
            if (out_valid2) begin
                if (fv2 < 0) fv2 = c;
                idx2 = int'(out_row2) * 2 + int'(out_col2);
                if (idx2 != nacc2) idx_err2++;
                nacc2++;
            end
            if (done2) begin done_n2++; done_c2 = c; end
            tick();
        end
        start2 = 1'b0;
        chk("n2.first_valid", fv2, 17);
        chk("n2.n_results", nacc2, 4);
        chk("n2.idx_seq_err", idx_err2, 0);
        chk("n2.done_cyc", done_c2, 21);
        chk("n2.done_n", done_n2, 1);
        chk("n2.busy_end", int'(busy2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
